// File: rtl/serial_ge_compare_pkg.sv
// Shared types and defaults for the bit-serial magnitude comparator.
// State encoding and the default operand width live here.
package serial_ge_compare_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_ge_compare_if.sv
// Request/result bundle of the serial comparator.
// master drives operands and start, slave returns status and flags.
interface serial_ge_compare_if
  import serial_ge_compare_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             ge_o;
  logic             eq_o;

  modport master (
    output start,
    output a,
    output b,
    input  ready,
    input  busy,
    input  done,
    input  ge_o,
    input  eq_o
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output ready,
    output busy,
    output done,
    output ge_o,
    output eq_o
  );

endinterface

// File: rtl/serial_ge_compare_ge.sv
// 1-bit greater-or-equal cell: ge = (x >= y) for single bits.
// Used in pairs to classify one bit position per cycle.
module serial_ge_compare_ge (
  input  logic x,
  input  logic y,
  output logic ge
);

  assign ge = x | ~y;

endmodule

// File: rtl/serial_ge_compare.sv
// Bit-serial MSB-first unsigned compare producing a>=b and a==b.
// One bit-pair per clock, optional exit at the first differing bit.
module serial_ge_compare
  import serial_ge_compare_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_ge_compare_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic             ge_q;
  logic             eq_q;
  logic             gab;
  logic             gba;
  logic             diff;
  logic             first;
  logic             last;
  logic             in_shift;
  logic             in_done;
  logic             accept;

  serial_ge_compare_ge u_gab (
    .x  (sa[WIDTH-1]),
    .y  (sb[WIDTH-1]),
    .ge (gab)
  );

  serial_ge_compare_ge u_gba (
    .x  (sb[WIDTH-1]),
    .y  (sa[WIDTH-1]),
    .ge (gba)
  );

  // exactly one cell true means the MSBs differ
  assign diff     = gab ^ gba;
  assign first    = diff & ~decided;
  assign last     = (cnt == '0);
  assign in_shift = (state == ST_SHIFT);
  assign in_done  = (state == ST_DONE);
  assign accept   = bus.start & ~(in_shift | in_done);

  assign bus.ready = ~(in_shift | in_done);
  assign bus.busy  = in_shift | in_done;
  assign bus.done  = in_done;
  assign bus.ge_o  = ge_q;
  assign bus.eq_o  = eq_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state; unused code 2'd3 behaves as idle
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      in_shift: begin
        if ((EARLY_EXIT && first) || last) begin
          state_nx = ST_DONE;
        end
      end
      in_done: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = accept ? ST_SHIFT : ST_IDLE;
      end
    endcase
  end

  // operand shifters, bit counter and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      ge_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else if (accept) begin
      sa      <= bus.a;
      sb      <= bus.b;
      cnt     <= CW'(WIDTH - 1);
      decided <= 1'b0;
      ge_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else if (in_shift) begin
      sa <= sa << 1;
      sb <= sb << 1;
      if (!last) begin
        cnt <= cnt - 1'b1;
      end
      if (first) begin
        ge_q    <= gab;
        eq_q    <= 1'b0;
        decided <= 1'b1;
      end else if (last && !decided) begin
        ge_q <= 1'b1;
        eq_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_ge_compare.sv
// Directed bench for serial_ge_compare, early-exit and fixed-latency.
// Cycle n is the clock period following the n-th edge after accept.
module tb_serial_ge_compare;

  localparam int W  = 8;
  localparam int NV = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_ge_compare_if #(.WIDTH(W)) bus_e ();
  serial_ge_compare_if #(.WIDTH(W)) bus_f ();

  serial_ge_compare #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e)
  );

  serial_ge_compare #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f)
  );

  typedef struct {
    bit         fixed;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
    logic       ge;
    logic       eq;
  } vec_t;

  vec_t vt [NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit fixed, input logic s,
                        input logic [7:0] a, input logic [7:0] b);
    if (fixed) begin
      bus_f.start = s;
      bus_f.a     = a;
      bus_f.b     = b;
    end else begin
      bus_e.start = s;
      bus_e.a     = a;
      bus_e.b     = b;
    end
  endtask

  // {ready, busy, done, ge_o, eq_o}
  function automatic logic [4:0] outs(input bit fixed);
    if (fixed) begin
      return {bus_f.ready, bus_f.busy, bus_f.done, bus_f.ge_o, bus_f.eq_o};
    end
    return {bus_e.ready, bus_e.busy, bus_e.done, bus_e.ge_o, bus_e.eq_o};
  endfunction

  // accept one operation and return the cycle in which done is seen
  task automatic run_op(input bit fixed, input logic [7:0] a,
                        input logic [7:0] b, output int cyc);
    logic [4:0] o;
    @(negedge clk);
    set_in(fixed, 1'b1, a, b);
    @(posedge clk);
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        set_in(fixed, 1'b0, 8'h00, 8'h00);
      end
      o = outs(fixed);
      if (o[2]) begin
        cyc = n;
        break;
      end
    end
  endtask

  initial begin
    logic [4:0] o;
    int         cyc;
    bit         seen;

    vt[0]  = '{1'b0, 8'hA5, 8'hA5, 9, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 8'h80, 8'h7F, 2, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 8'h12, 8'h13, 9, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'hFF, 8'h00, 2, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h3C, 8'h38, 7, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 8'h00, 9, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 8'h01, 8'h02, 8, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h80, 8'h00, 9, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 8'h00, 8'h01, 9, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 8'h55, 8'h55, 9, 1'b1, 1'b1};
    vt[10] = '{1'b1, 8'h7F, 8'h80, 9, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'hFE, 8'hFF, 9, 1'b0, 1'b0};
    vt[12] = '{1'b1, 8'h81, 8'h7F, 9, 1'b1, 1'b0};

    set_in(1'b0, 1'b0, 8'h00, 8'h00);
    set_in(1'b1, 1'b0, 8'h00, 8'h00);

    #1;
    chk("reset outs early", 32'(outs(1'b0)), 32'b10000);
    chk("reset outs fixed", 32'(outs(1'b1)), 32'b10000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].fixed, vt[i].a, vt[i].b, cyc);
      o = outs(vt[i].fixed);
      chk($sformatf("v%0d done cycle", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d ge", i), 32'(o[1]), 32'(vt[i].ge));
      chk($sformatf("v%0d eq", i), 32'(o[0]), 32'(vt[i].eq));
      @(negedge clk);
      o = outs(vt[i].fixed);
      chk($sformatf("v%0d ready after", i), 32'(o[4]), 32'd1);
      chk($sformatf("v%0d done pulse", i), 32'(o[2]), 32'd0);
      chk($sformatf("v%0d ge held", i), 32'(o[1]), 32'(vt[i].ge));
    end

    // back-to-back: start held through DONE, accepted in cycle 10
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'h12, 8'h13);
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      o = outs(1'b0);
      if (n == 1) set_in(1'b0, 1'b0, 8'h00, 8'h00);
      if (n == 9) begin
        chk("b2b first done", 32'(o[2]), 32'd1);
        chk("b2b first ge", 32'(o[1]), 32'd0);
        set_in(1'b0, 1'b1, 8'hFF, 8'h00);
      end
      if (n == 10) begin
        chk("b2b idle ready", 32'(o[4]), 32'd1);
        chk("b2b idle done", 32'(o[2]), 32'd0);
      end
      if (n == 11) begin
        set_in(1'b0, 1'b0, 8'h00, 8'h00);
        chk("b2b second busy", 32'(o[3]), 32'd1);
      end
      if (n == 12) begin
        chk("b2b second done", 32'(o[2]), 32'd1);
        chk("b2b second ge", 32'(o[1]), 32'd1);
        chk("b2b second eq", 32'(o[0]), 32'd0);
      end
    end

    // start pulsed during SHIFT and DONE must be ignored
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'h10, 8'h20);
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      o = outs(1'b0);
      if (n == 1) set_in(1'b0, 1'b0, 8'h00, 8'h00);
      if (n == 3) begin
        chk("ign no done c3", 32'(o[2]), 32'd0);
        set_in(1'b0, 1'b1, 8'hFF, 8'h00);
      end
      if (n == 4) begin
        chk("ign done c4", 32'(o[2]), 32'd1);
        chk("ign ge", 32'(o[1]), 32'd0);
      end
      if (n == 5) begin
        set_in(1'b0, 1'b0, 8'h00, 8'h00);
        chk("ign idle busy", 32'(o[3]), 32'd0);
      end
      if (n == 6) begin
        chk("ign still idle", 32'(o[4]), 32'd1);
        chk("ign ge kept", 32'(o[1]), 32'd0);
      end
    end

    // asynchronous reset in SHIFT cycle 3
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'h01, 8'h00);
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) set_in(1'b0, 1'b0, 8'h00, 8'h00);
    end
    chk("rst pre busy", 32'(outs(1'b0)), 32'b01000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async outs", 32'(outs(1'b0)), 32'b10000);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (outs(1'b0) != 5'b10000) seen = 1'b1;
    end
    chk("rst no done", 32'(seen), 32'd0);
    rst_n = 1'b1;
    run_op(1'b0, 8'h05, 8'h05, cyc);
    o = outs(1'b0);
    chk("post rst cycle", cyc, 32'd9);
    chk("post rst ge", 32'(o[1]), 32'd1);
    chk("post rst eq", 32'(o[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
